microcode_sequencer: RTL and testbench
======================================

// Module: microcode_sequencer
// PURPOSE
//  Parametrised microcode sequencer. Replaces the flat next-command logic with a stepped engine:
//  accepts a command from decode, walks cmd/cmdex/step using an external autogen table lookup,
//  supports CALL/RETURN through a LIFO of saved (cmd,cmdex), and hands each micro-op to execute.
//  Handshakes are valid/ready on both sides. Sits between the decode stage and the microcode/execute stage.
// PARAMETERS
//  CMD_W        7  command width
//  CMDEX_W      4  command-extension width
//  STEP_W       6  step counter width
//  STACK_DEPTH  2  saved-command LIFO entries (>=1)
//  LOOP_W       8  loop counter width (used only with MC_SEQ_LOOP_EN)
// PORTS
//  clk            in   1         clock; all state updates on rising edge
//  rst            in   1         synchronous reset, active-high
//  flush          in   1         synchronous pipeline flush
//  in_valid       in   1         decode presents a command
//  in_ready       out  1         sequencer can accept a command
//  in_cmd         in   CMD_W     first command
//  in_cmdex       in   CMDEX_W   first cmdex
//  out_valid      out  1         micro-op valid to execute
//  out_ready      in   1         execute accepts micro-op
//  out_cmd        out  CMD_W     current command
//  out_cmdex      out  CMDEX_W   current cmdex
//  out_step       out  STEP_W    micro-op index within instruction
//  out_last       out  1         current micro-op ends the instruction
//  tbl_kind       in   3         table directive for current cmd/cmdex: 0 END,1 NEXT,2 JUMP,3 CALL,4 RETURN,5 LOOP
//  tbl_cmd_next   in   CMD_W     target command (JUMP/CALL)
//  tbl_cmdex_next in   CMDEX_W   target cmdex (NEXT/JUMP); return cmdex for CALL
//  tbl_loop_count in   LOOP_W    extra repeats for LOOP
//  stack_level    out  $clog2(STACK_DEPTH+1)  LIFO occupancy
//  err_overflow   out  1         sticky: CALL with full LIFO
// BEHAVIOUR
//  - Reset: IDLE; in_ready=0 in reset cycle, 1 in next cycle; out_* =0; stack_level=0; err_overflow=0.
//  - States: IDLE (in_ready=1, out_valid=0), RUN (in_ready=0, out_valid=1), HALT (both 0).
//  - IDLE: in_valid&in_ready -> load cmd/cmdex, step=0, RUN next cycle (1-cycle latency to out_valid).
//  - RUN: advance only on out_valid&out_ready; out_* held stable otherwise. Directive on acceptance:
//    END: stack empty -> IDLE; not empty -> behaves as RETURN.
//    NEXT: cmdex<=tbl_cmdex_next. JUMP: cmd<=tbl_cmd_next, cmdex<=tbl_cmdex_next.
//    CALL: push (cmd,tbl_cmdex_next); cmd<=tbl_cmd_next, cmdex<=0. Full LIFO -> err_overflow=1, HALT.
//    RETURN: pop into cmd/cmdex; empty LIFO -> as END. Unused codes 6/7 treated as END.
//  - step increments on every acceptance except end of instruction; saturates at all-ones.
//  - out_last = directive resolves to IDLE (END or RETURN/END with empty LIFO).
//  - New instruction never accepted in same cycle as last micro-op: one idle bubble (in_ready next cycle).
//  - flush: priority below rst, above all else. Next cycle IDLE, LIFO empty, err_overflow cleared,
//    loop counter cleared; flush with in_valid -> command NOT accepted (in_ready forced 0 while flush).
//  - HALT exits only by flush or rst.
//  - tbl_* sampled only on out_valid&out_ready; values outside that cycle ignored.
// CONFIGURATION
//  MC_SEQ_LOOP_EN defined: LOOP directive on first acceptance loads counter=tbl_loop_count;
//   counter!=0 -> repeat same cmd/cmdex, decrement, step++; counter==0 -> proceed as NEXT.
//   tbl_loop_count=0 behaves as NEXT. Loop counter not saved across CALL (CALL inside loop is illegal; ignored).
//  MC_SEQ_LOOP_EN undefined: LOOP treated as NEXT; tbl_loop_count unused; no counter flops.
// STRUCTURE
//  Package mc_seq_pkg: kind encodings (MC_KIND_END..MC_KIND_LOOP), state encodings, default widths.
//  Sub-module mc_seq_stack: parametrised LIFO (push/pop/full/empty/level, sync active-high reset + clear).
//  Top holds FSM, cmd/cmdex/step registers, optional loop counter.
// TESTING
//  1 in cmd=7'h12 cmdex=0; table NEXT->1, NEXT->2, END; out_ready=1 -> 3 ops, steps 0,1,2, out_last on step 2, in_ready next cycle.
//  2 out_ready held 0 for 5 cycles mid-instruction -> out_cmd/cmdex/step stable, no advance.
//  3 STACK_DEPTH=2: CALL,CALL,RETURN,RETURN,END -> stack_level 1,2,1,0; return cmdex = tbl_cmdex_next of each CALL.
//  4 third nested CALL with depth 2 -> err_overflow=1, state HALT, out_valid=0; flush -> IDLE, err cleared.
//  5 flush with in_valid=1 during RUN -> no acceptance that cycle; next cycle IDLE, in_ready=1, stack_level=0.
//  6 MC_SEQ_LOOP_EN, LOOP count 3 -> same cmdex issued 4 times (steps n..n+3), then NEXT target; undefined -> issued once.

Source files
------------

// File: rtl/mc_seq_pkg.sv
// Shared encodings and default widths for the microcode sequencer.
package mc_seq_pkg;

    localparam int unsigned MC_CMD_W       = 7;
    localparam int unsigned MC_CMDEX_W     = 4;
    localparam int unsigned MC_STEP_W      = 6;
    localparam int unsigned MC_STACK_DEPTH = 2;
    localparam int unsigned MC_LOOP_W      = 8;
    localparam int unsigned MC_KIND_W      = 3;

    // Table directive encodings; codes 6 and 7 are unused and act as END.
    localparam logic [MC_KIND_W-1:0] MC_KIND_END    = 3'd0;
    localparam logic [MC_KIND_W-1:0] MC_KIND_NEXT   = 3'd1;
    localparam logic [MC_KIND_W-1:0] MC_KIND_JUMP   = 3'd2;
    localparam logic [MC_KIND_W-1:0] MC_KIND_CALL   = 3'd3;
    localparam logic [MC_KIND_W-1:0] MC_KIND_RETURN = 3'd4;
    localparam logic [MC_KIND_W-1:0] MC_KIND_LOOP   = 3'd5;

    typedef enum logic [1:0] {
        MC_ST_IDLE = 2'd0,
        MC_ST_RUN  = 2'd1,
        MC_ST_HALT = 2'd2
    } mc_state_e;

endpackage

// File: rtl/mc_seq_stack.sv
// LIFO of saved (cmd,cmdex) return points; clear empties it in one cycle.
module mc_seq_stack
    import mc_seq_pkg::*;
#(
    parameter int unsigned DEPTH = MC_STACK_DEPTH,
    parameter int unsigned W     = MC_CMD_W + MC_CMDEX_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 push_data,
    output logic [W-1:0]                 top_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [LVL_W-1:0] level_q;

    // Occupancy: push wins over pop; overfull push and empty pop are dropped.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            level_q <= '0;
        end else if (push && !full) begin
            level_q <= level_q + LVL_W'(1);
        end else if (pop && !empty) begin
            level_q <= level_q - LVL_W'(1);
        end
    end

    // Entry storage; contents above the level are don't-care.
    always_ff @(posedge clk) begin
        if (push && !full && !rst && !clear) begin
            mem[IDX_W'(level_q)] <= push_data;
        end
    end

    assign top_data = mem[IDX_W'(level_q - LVL_W'(1))];
    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;

endmodule

// File: rtl/microcode_sequencer.sv
// Stepped microcode sequencer between decode and execute.
// Optional feature: define MC_SEQ_LOOP_EN to enable the LOOP directive repeat counter;
// without it LOOP behaves as NEXT and no counter state exists.
module microcode_sequencer
    import mc_seq_pkg::*;
#(
    parameter int unsigned CMD_W       = MC_CMD_W,
    parameter int unsigned CMDEX_W     = MC_CMDEX_W,
    parameter int unsigned STEP_W      = MC_STEP_W,
    parameter int unsigned STACK_DEPTH = MC_STACK_DEPTH,
    parameter int unsigned LOOP_W      = MC_LOOP_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [CMD_W-1:0]                  in_cmd,
    input  logic [CMDEX_W-1:0]                in_cmdex,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CMD_W-1:0]                  out_cmd,
    output logic [CMDEX_W-1:0]                out_cmdex,
    output logic [STEP_W-1:0]                 out_step,
    output logic                              out_last,
    input  logic [MC_KIND_W-1:0]              tbl_kind,
    input  logic [CMD_W-1:0]                  tbl_cmd_next,
    input  logic [CMDEX_W-1:0]                tbl_cmdex_next,
    input  logic [LOOP_W-1:0]                 tbl_loop_count,
    output logic [$clog2(STACK_DEPTH+1)-1:0]  stack_level,
    output logic                              err_overflow
);

    localparam int unsigned ENT_W = CMD_W + CMDEX_W;

    mc_state_e          state, state_next;
    logic [CMD_W-1:0]   cmd_q;
    logic [CMDEX_W-1:0] cmdex_q;
    logic [STEP_W-1:0]  step_q;
    logic               err_q;

    logic accept_in, accept_out;
    logic is_end, is_ret, is_next, is_jump, is_call, is_loop;
    logic finish, do_pop, overflow, loop_repeat;
    logic stack_push, stack_pop, stack_full, stack_empty;
    logic [ENT_W-1:0] stack_top;

    // Directive decode; unused codes fall into END.
    always_comb begin
        is_end  = 1'b0;
        is_ret  = 1'b0;
        is_next = 1'b0;
        is_jump = 1'b0;
        is_call = 1'b0;
        is_loop = 1'b0;
        case (tbl_kind)
            MC_KIND_NEXT:   is_next = 1'b1;
            MC_KIND_JUMP:   is_jump = 1'b1;
            MC_KIND_CALL:   is_call = 1'b1;
            MC_KIND_RETURN: is_ret  = 1'b1;
            MC_KIND_LOOP:   is_loop = 1'b1;
            default:        is_end  = 1'b1;
        endcase
    end

    // END and RETURN unwind the LIFO; with nothing saved they end the instruction.
    assign finish   = (is_end || is_ret) && stack_empty;
    assign do_pop   = (is_end || is_ret) && !stack_empty;
    assign overflow = is_call && stack_full;

`ifdef MC_SEQ_LOOP_EN
    logic [LOOP_W-1:0] loop_cnt_q;
    logic [LOOP_W-1:0] loop_cnt_eff;
    logic              loop_active_q;

    assign loop_cnt_eff = loop_active_q ? loop_cnt_q : tbl_loop_count;
    assign loop_repeat  = is_loop && (loop_cnt_eff != '0);

    // Remaining repeats: loaded on the first LOOP acceptance, dropped on any other directive.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            loop_cnt_q    <= '0;
            loop_active_q <= 1'b0;
        end else if (accept_out) begin
            if (loop_repeat) begin
                loop_cnt_q    <= loop_cnt_eff - LOOP_W'(1);
                loop_active_q <= 1'b1;
            end else begin
                loop_cnt_q    <= '0;
                loop_active_q <= 1'b0;
            end
        end
    end
`else
    logic unused_loop_count;
    assign unused_loop_count = ^tbl_loop_count;
    assign loop_repeat       = 1'b0;
`endif

    // State register; flush returns to IDLE from any state.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= MC_ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: HALT is left only through flush or reset.
    always_comb begin
        state_next = state;
        case (state)
            MC_ST_IDLE: if (accept_in) state_next = MC_ST_RUN;
            MC_ST_RUN: begin
                if (accept_out) begin
                    if (finish) begin
                        state_next = MC_ST_IDLE;
                    end else if (overflow) begin
                        state_next = MC_ST_HALT;
                    end
                end
            end
            MC_ST_HALT: state_next = MC_ST_HALT;
            default:    state_next = MC_ST_IDLE;
        endcase
    end

    // Handshake and LIFO control decoded from the current state.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        accept_in  = 1'b0;
        accept_out = 1'b0;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        case (state)
            MC_ST_IDLE: begin
                in_ready  = !rst && !flush;
                accept_in = in_valid && in_ready;
            end
            MC_ST_RUN: begin
                out_valid  = 1'b1;
                out_last   = finish;
                accept_out = out_ready && !rst && !flush;
                stack_push = accept_out && is_call && !stack_full;
                stack_pop  = accept_out && do_pop;
            end
            default: ;
        endcase
    end

    // Command/cmdex/step walk and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q   <= '0;
            cmdex_q <= '0;
            step_q  <= '0;
            err_q   <= 1'b0;
        end else if (flush) begin
            err_q <= 1'b0;
        end else if (accept_in) begin
            cmd_q   <= in_cmd;
            cmdex_q <= in_cmdex;
            step_q  <= '0;
        end else if (accept_out) begin
            if (overflow) begin
                err_q <= 1'b1;
            end else if (!finish) begin
                if (step_q != '1) step_q <= step_q + STEP_W'(1);
                if (do_pop) begin
                    {cmd_q, cmdex_q} <= stack_top;
                end else if (is_call) begin
                    cmd_q   <= tbl_cmd_next;
                    cmdex_q <= '0;
                end else if (is_jump) begin
                    cmd_q   <= tbl_cmd_next;
                    cmdex_q <= tbl_cmdex_next;
                end else if (is_next || (is_loop && !loop_repeat)) begin
                    cmdex_q <= tbl_cmdex_next;
                end
            end
        end
    end

    mc_seq_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ENT_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (stack_push),
        .pop       (stack_pop),
        .push_data ({cmd_q, tbl_cmdex_next}),
        .top_data  (stack_top),
        .full      (stack_full),
        .empty     (stack_empty),
        .level     (stack_level)
    );

    assign out_cmd      = cmd_q;
    assign out_cmdex    = cmdex_q;
    assign out_step     = step_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios plus random table programs,
// each micro-op compared against a trace-level model of the command walk.
`timescale 1ns/1ps
module tb_microcode_sequencer;

    localparam int DEPTH = 2;
    localparam logic [2:0] K_END  = 3'd0;
    localparam logic [2:0] K_NEXT = 3'd1;
    localparam logic [2:0] K_JUMP = 3'd2;
    localparam logic [2:0] K_CALL = 3'd3;
    localparam logic [2:0] K_RET  = 3'd4;
    localparam logic [2:0] K_LOOP = 3'd5;

    logic       clk, rst, flush;
    logic       in_valid, in_ready;
    logic [6:0] in_cmd;
    logic [3:0] in_cmdex;
    logic       out_valid, out_ready, out_last;
    logic [6:0] out_cmd;
    logic [3:0] out_cmdex;
    logic [5:0] out_step;
    logic [2:0] tbl_kind;
    logic [6:0] tbl_cmd_next;
    logic [3:0] tbl_cmdex_next;
    logic [7:0] tbl_loop_count;
    logic [1:0] stack_level;
    logic       err_overflow;

    microcode_sequencer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_cmdex(in_cmdex),
        .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd), .out_cmdex(out_cmdex),
        .out_step(out_step), .out_last(out_last),
        .tbl_kind(tbl_kind), .tbl_cmd_next(tbl_cmd_next), .tbl_cmdex_next(tbl_cmdex_next),
        .tbl_loop_count(tbl_loop_count), .stack_level(stack_level), .err_overflow(err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] kind;
        logic [6:0] cn;
        logic [3:0] xn;
        logic [7:0] lc;
    } dir_t;

    dir_t        prog[$];
    logic [10:0] m_stk[$];
    int          tests_run = 0;
    int          tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input logic [2:0] k, input logic [6:0] cn, input logic [3:0] xn, input logic [7:0] lc);
        dir_t d;
        d.kind = k; d.cn = cn; d.xn = xn; d.lc = lc;
        prog.push_back(d);
    endtask

    // Issue one instruction and follow it to completion (or overflow) against the model.
    task automatic run_instr(input logic [6:0] c, input logic [3:0] x, input int ready_pct,
                             input int stall, output int n_ops, output bit ovf);
        logic [6:0] m_cmd;
        logic [3:0] m_cmdex;
        int         m_step, idx, rep_left, waitc;
        bit         in_loop, done, last_exp, adv;
        dir_t       d;
        n_ops = 0; ovf = 0; done = 0; waitc = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_cmd = c; in_cmdex = x;
        @(posedge clk); #1;
        in_valid = 1'b0; in_cmd = 7'($urandom); in_cmdex = 4'($urandom);
        m_cmd = c; m_cmdex = x; m_step = 0; idx = 0; rep_left = 0; in_loop = 0;
        m_stk.delete();
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (idx >= prog.size()) begin
                chk("program_overrun", idx, prog.size());
                break;
            end
            d = prog[idx];
            if (stall > 0 && idx == 1) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = (int'($urandom_range(0, 99)) < ready_pct);
            end
            if (out_ready) begin
                tbl_kind = d.kind; tbl_cmd_next = d.cn; tbl_cmdex_next = d.xn; tbl_loop_count = d.lc;
            end else begin
                tbl_kind = 3'($urandom); tbl_cmd_next = 7'($urandom);
                tbl_cmdex_next = 4'($urandom); tbl_loop_count = 8'($urandom);
            end
            @(negedge clk);
            chk("out_valid", out_valid, 1);
            chk("in_ready_busy", in_ready, 0);
            chk("out_cmd", out_cmd, m_cmd);
            chk("out_cmdex", out_cmdex, m_cmdex);
            chk("out_step", out_step, m_step);
            chk("level", stack_level, m_stk.size());
            if (out_ready) begin
                n_ops++;
                adv = 1; last_exp = 0;
                case (d.kind)
                    K_NEXT: m_cmdex = d.xn;
                    K_JUMP: begin m_cmd = d.cn; m_cmdex = d.xn; end
                    K_CALL: begin
                        if (m_stk.size() == DEPTH) begin
                            ovf = 1; done = 1;
                        end else begin
                            m_stk.push_back({m_cmd, d.xn});
                            m_cmd = d.cn; m_cmdex = 4'd0;
                        end
                    end
                    K_LOOP: begin
`ifdef MC_SEQ_LOOP_EN
                        if (!in_loop) begin in_loop = 1; rep_left = int'(d.lc); end
                        if (rep_left > 0) begin
                            rep_left--; adv = 0;
                        end else begin
                            in_loop = 0; m_cmdex = d.xn;
                        end
`else
                        m_cmdex = d.xn;
`endif
                    end
                    default: begin
                        if (m_stk.size() == 0) begin
                            last_exp = 1; done = 1;
                        end else begin
                            {m_cmd, m_cmdex} = m_stk.pop_back();
                        end
                    end
                endcase
                if (!done) m_step = (m_step < 63) ? m_step + 1 : 63;
                chk("out_last", out_last, last_exp);
                if (adv) idx++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        if (!done) chk("instr_timeout", 0, 1);
        @(negedge clk);
        if (ovf) begin
            chk("halt_out_valid", out_valid, 0);
            chk("halt_in_ready", in_ready, 0);
            chk("halt_err", err_overflow, 1);
        end else begin
            chk("end_out_valid", out_valid, 0);
            chk("end_in_ready", in_ready, 1);
            chk("end_level", stack_level, 0);
            chk("end_err", err_overflow, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        bit         ov;
        int         depth, len, r;
        logic [2:0] term;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_cmd = '0; in_cmdex = '0; out_ready = 1'b0;
        tbl_kind = '0; tbl_cmd_next = '0; tbl_cmdex_next = '0; tbl_loop_count = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_cmd", out_cmd, 0);
        chk("rst_out_cmdex", out_cmdex, 0);
        chk("rst_out_step", out_step, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_level", stack_level, 0);
        chk("rst_err", err_overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Simple NEXT, NEXT, END walk
        prog.delete();
        add(K_NEXT, 7'h0, 4'h1, 8'd0); add(K_NEXT, 7'h0, 4'h2, 8'd0); add(K_END, 7'h0, 4'h0, 8'd0);
        run_instr(7'h12, 4'h0, 100, 0, n, ov);
        chk("t1_ops", n, 3);

        // Five-cycle stall on the second micro-op
        prog.delete();
        add(K_NEXT, 7'h0, 4'h3, 8'd0); add(K_NEXT, 7'h0, 4'h4, 8'd0); add(K_END, 7'h0, 4'h0, 8'd0);
        run_instr(7'h21, 4'h5, 100, 5, n, ov);
        chk("t2_ops", n, 3);

        // Nested CALL/RETURN
        prog.delete();
        add(K_CALL, 7'h30, 4'h7, 8'd0); add(K_CALL, 7'h40, 4'h9, 8'd0);
        add(K_RET, 7'h0, 4'h0, 8'd0); add(K_RET, 7'h0, 4'h0, 8'd0); add(K_END, 7'h0, 4'h0, 8'd0);
        run_instr(7'h20, 4'h1, 100, 0, n, ov);
        chk("t3_ops", n, 5);

        // Third nested CALL overflows, then flush recovers
        prog.delete();
        add(K_CALL, 7'h30, 4'h1, 8'd0); add(K_CALL, 7'h31, 4'h2, 8'd0); add(K_CALL, 7'h32, 4'h3, 8'd0);
        run_instr(7'h10, 4'h0, 100, 0, n, ov);
        chk("t4_ovf", ov, 1);
        repeat (3) @(negedge clk);
        chk("t4_halt_hold", out_valid, 0);
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("t4_flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t4_err_cleared", err_overflow, 0);
        chk("t4_level", stack_level, 0);
        chk("t4_in_ready", in_ready, 1);

        // Flush with in_valid during RUN
        in_valid = 1'b1; in_cmd = 7'h44; in_cmdex = 4'h0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tbl_kind = K_CALL; tbl_cmd_next = 7'h50; tbl_cmdex_next = 4'h2; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t5_level", stack_level, 1);
        chk("t5_cmd", out_cmd, 7'h50);
        flush = 1'b1; in_valid = 1'b1; in_cmd = 7'h66;
        #1;
        chk("t5_flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_level_clear", stack_level, 0);

        // LOOP with count 3
        prog.delete();
        add(K_NEXT, 7'h0, 4'h2, 8'd0); add(K_LOOP, 7'h0, 4'h5, 8'd3); add(K_END, 7'h0, 4'h0, 8'd0);
        run_instr(7'h33, 4'h0, 100, 0, n, ov);
`ifdef MC_SEQ_LOOP_EN
        chk("t6_ops", n, 6);
`else
        chk("t6_ops", n, 3);
`endif

        // Step counter saturation
        prog.delete();
        for (int i = 0; i < 66; i++) add(K_NEXT, 7'h0, 4'(i), 8'd0);
        add(K_END, 7'h0, 4'h0, 8'd0);
        run_instr(7'h01, 4'h0, 100, 0, n, ov);
        chk("t7_ops", n, 67);

        // Random programs with random back-pressure
        for (int it = 0; it < 20; it++) begin
            prog.delete();
            depth = 0;
            len = int'($urandom_range(3, 12));
            for (int i = 0; i < len; i++) begin
                r = int'($urandom_range(0, 5));
                case (r)
                    0: add(K_NEXT, 7'($urandom), 4'($urandom), 8'd0);
                    1: add(K_JUMP, 7'($urandom), 4'($urandom), 8'd0);
                    2: if (depth < DEPTH) begin
                           add(K_CALL, 7'($urandom), 4'($urandom), 8'd0); depth++;
                       end else add(K_NEXT, 7'h0, 4'($urandom), 8'd0);
                    3: if (depth > 0) begin
                           add(($urandom_range(0, 1) == 0) ? K_RET : K_END, 7'h0, 4'h0, 8'd0); depth--;
                       end else add(K_NEXT, 7'h0, 4'($urandom), 8'd0);
                    4: add(K_LOOP, 7'($urandom), 4'($urandom), 8'($urandom_range(0, 3)));
                    default: add(K_NEXT, 7'($urandom), 4'($urandom), 8'd0);
                endcase
            end
            for (int i = 0; i <= depth; i++) begin
                case ($urandom_range(0, 3))
                    0: term = K_END;
                    1: term = K_RET;
                    2: term = 3'd6;
                    default: term = 3'd7;
                endcase
                add(term, 7'($urandom), 4'($urandom), 8'($urandom));
            end
            run_instr(7'($urandom), 4'($urandom), int'($urandom_range(30, 100)), 0, n, ov);
            chk("rand_no_ovf", ov, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
